// File: rtl/alu_share_sched_if.sv
// Request/response bundle between the two ALU requesters and the scheduler.
// master = requesters plus response consumer, slave = alu_share_sched.
interface alu_share_sched_if #(
  parameter int DATA_W = 8,
  parameter int OP_W   = 5
);
  logic [1:0]        reqValid;
  logic [1:0]        reqReady;
  logic [OP_W-1:0]   reqOp0;
  logic [OP_W-1:0]   reqOp1;
  logic [DATA_W-1:0] reqA0;
  logic [DATA_W-1:0] reqA1;
  logic [DATA_W-1:0] reqB0;
  logic [DATA_W-1:0] reqB1;
  logic              rspValid;
  logic              rspReady;
  logic              rspId;
  logic [DATA_W-1:0] rspResult;
  logic              rspBranch;
  logic              rspErr;

  modport master (
    output reqValid, reqOp0, reqOp1,
    output reqA0, reqA1, reqB0, reqB1,
    output rspReady,
    input  reqReady, rspValid, rspId,
    input  rspResult, rspBranch, rspErr
  );

  modport slave (
    input  reqValid, reqOp0, reqOp1,
    input  reqA0, reqA1, reqB0, reqB1,
    input  rspReady,
    output reqReady, rspValid, rspId,
    output rspResult, rspBranch, rspErr
  );
endinterface

// File: rtl/alu_share_sched.sv
// Shares one ALU between execute (req0) and branch/address unit (req1).
// Define ALU_SCHED_MODCHK_EN to trap MOD-by-zero before it reaches the ALU.
module alu_share_sched #(
  parameter int DATA_W     = 8,
  parameter int OP_W       = 5,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              reset,
  alu_share_sched_if.slave  bus,
  output logic [OP_W-1:0]   aluOp,
  output logic [DATA_W-1:0] aluInOne,
  output logic [DATA_W-1:0] aluInTwo,
  input  logic [DATA_W-1:0] aluResult,
  input  logic              aluBranchPass
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [OP_W-1:0]   op_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] res_q;
  logic              owner_q;
  logic              last_q;
  logic              br_q;
  logic              flag_q;

  logic              accept;
  logic              win;
  logic              modz;
  logic              is_br;
  logic [OP_W-1:0]   sel_op;
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;

  always_comb begin
    win = 1'b0;
    unique case (bus.reqValid)
      2'b10:   win = 1'b1;
      2'b11:   win = (FIXED_PRIO != 0) ? 1'b0 : ~last_q;
      default: win = 1'b0;
    endcase
  end

  assign sel_op = win ? bus.reqOp1 : bus.reqOp0;
  assign sel_a  = win ? bus.reqA1  : bus.reqA0;
  assign sel_b  = win ? bus.reqB1  : bus.reqB0;

`ifdef ALU_SCHED_MODCHK_EN
  logic err_q;

  assign modz = (sel_op == OP_W'(5'b01111))
             && (sel_b == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (state_q == EXEC) begin
      err_q <= flag_q;
    end
  end

  assign bus.rspErr = err_q;
`else
  assign modz       = 1'b0;
  assign bus.rspErr = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    accept       = 1'b0;
    bus.reqReady = 2'b00;
    unique case (state_q)
      IDLE: begin
        if ((|bus.reqValid) && !reset) begin
          accept       = 1'b1;
          bus.reqReady = win ? 2'b10 : 2'b01;
          state_d      = EXEC;
        end
      end
      EXEC: state_d = RESP;
      RESP: begin
        if (bus.rspReady) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Branch ops live in 101xx and 110xx; others never report a branch.
  assign is_br = (op_q[4:2] == 3'b101)
              || (op_q[4:2] == 3'b110);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      br_q    <= 1'b0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q    <= modz ? '0 : sel_op;
        a_q     <= modz ? '0 : sel_a;
        b_q     <= modz ? '0 : sel_b;
        owner_q <= win;
        last_q  <= win;
        flag_q  <= modz;
      end
      if (state_q == EXEC) begin
        res_q <= flag_q ? '1 : aluResult;
        br_q  <= !flag_q && is_br
              && aluBranchPass;
      end
    end
  end

  assign aluOp         = op_q;
  assign aluInOne      = a_q;
  assign aluInTwo      = b_q;
  assign bus.rspValid  = (state_q == RESP);
  assign bus.rspId     = owner_q;
  assign bus.rspResult = res_q;
  assign bus.rspBranch = br_q;

endmodule
